// File: rtl/eth_tx_frame_arb.sv
// eth_tx_frame_arb
// Frame-granular round-robin arbiter that shares one 8-bit AXI4-Stream GMII
// transmitter between NUM_PORTS frame sources. One port is granted per frame.
// Beats pass through a single registered output stage. Frames longer than
// MAX_FRAME_LEN beats are cut short, and the rest of the frame is discarded.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   s_axis_t*             per-port input streams (data packed, port i at [8i+7:8i])
//   m_axis_t*             single output stream towards the MAC s_axis_* inputs
//   grant_port            currently / most recently granted port index
//   busy                  high while a frame is granted (forwarding or dropping)
//   error_truncated       one-cycle pulse when a frame is force-terminated
//
// Optional feature (macro TX_ARB_STATS_EN):
//   stat_frames, stat_trunc  per-port saturating counters of completed and
//                            truncated frames, CNT_WIDTH bits per port.
`timescale 1ns/1ps

module eth_tx_frame_arb #(
  parameter int NUM_PORTS     = 3,
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  input  logic [NUM_PORTS-1:0]            s_axis_tuser,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tuser,
  output logic [2:0]                      grant_port,
  output logic                            busy,
  output logic                            error_truncated
`ifdef TX_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]  stat_frames,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]  stat_trunc
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  localparam logic [3:0]           NP4       = 4'(NUM_PORTS);
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(MAX_FRAME_LEN - 1);

  logic [1:0]           state_reg;
  logic [2:0]           rr_ptr_reg;
  logic [CNT_WIDTH-1:0] beat_cnt_reg;

  logic [NUM_PORTS-1:0]  gnt_oh;
  logic [NUM_PORTS-1:0]  rot_req;
  logic [2:0]            rr_off;
  logic [3:0]            win_sum;
  logic [2:0]            rr_next;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  sel_user;
  logic                  sel_ready;
  logic                  out_free;
  logic                  in_hs;
  logic                  frame_done;
  logic                  trunc;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_oh
      assign gnt_oh[gi] = (grant_port == 3'(gi));
    end
  endgenerate

  // Rotate the request vector so bit 0 corresponds to rr_ptr. The lowest set
  // bit is then the offset of the next port in round-robin order.
  assign rot_req = NUM_PORTS'({s_axis_tvalid, s_axis_tvalid} >> rr_ptr_reg);

  always_comb begin
    rr_off = 3'd0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (rot_req[i]) rr_off = 3'(i);
    end
    sel_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt_oh[i]) sel_data = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // rr_ptr and rr_off are both below NUM_PORTS, so one conditional subtract wraps.
  assign win_sum   = {1'b0, rr_ptr_reg} + {1'b0, rr_off};
  assign rr_next   = (grant_port == 3'(NUM_PORTS - 1)) ? 3'd0 : grant_port + 3'd1;

  assign sel_valid = |(s_axis_tvalid & gnt_oh);
  assign sel_last  = |(s_axis_tlast  & gnt_oh);
  assign sel_user  = |(s_axis_tuser  & gnt_oh);

  // The output register can take a new beat when it is empty or drained this cycle.
  assign out_free  = !m_axis_tvalid || m_axis_tready;
  assign sel_ready = ((state_reg == ST_PASS) && out_free) || (state_reg == ST_DROP);
  assign s_axis_tready = gnt_oh & {NUM_PORTS{sel_ready}};

  assign in_hs      = sel_valid && sel_ready;
  assign frame_done = in_hs && sel_last;
  assign trunc      = (state_reg == ST_PASS) && in_hs && !sel_last &&
                      (beat_cnt_reg == LAST_BEAT);

  assign busy = (state_reg != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      rr_ptr_reg      <= 3'd0;
      beat_cnt_reg    <= '0;
      grant_port      <= 3'd0;
      m_axis_tdata    <= '0;
      m_axis_tvalid   <= 1'b0;
      m_axis_tlast    <= 1'b0;
      m_axis_tuser    <= 1'b0;
      error_truncated <= 1'b0;
    end else begin
      error_truncated <= trunc;

      // The truncating beat is emitted as a bad, terminated frame.
      if ((state_reg == ST_PASS) && in_hs) begin
        m_axis_tdata  <= sel_data;
        m_axis_tlast  <= sel_last | trunc;
        m_axis_tuser  <= sel_user | trunc;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          // Hold off the next grant while a previous last beat is still stalled.
          if ((|s_axis_tvalid) && out_free) begin
            grant_port   <= 3'(win_sum >= NP4 ? win_sum - NP4 : win_sum);
            beat_cnt_reg <= '0;
            state_reg    <= ST_PASS;
          end
        end
        ST_PASS: begin
          if (in_hs) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
            if (frame_done) begin
              rr_ptr_reg <= rr_next;
              state_reg  <= ST_IDLE;
            end else if (trunc) begin
              state_reg  <= ST_DROP;
            end
          end
        end
        ST_DROP: begin
          if (frame_done) begin
            rr_ptr_reg <= rr_next;
            state_reg  <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef TX_ARB_STATS_EN
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_stats
      logic [CNT_WIDTH-1:0] frames_reg;
      logic [CNT_WIDTH-1:0] trunc_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          frames_reg <= '0;
          trunc_reg  <= '0;
        end else begin
          if (frame_done && gnt_oh[gi] && (frames_reg != '1)) frames_reg <= frames_reg + 1'b1;
          if (trunc && gnt_oh[gi] && (trunc_reg != '1))       trunc_reg  <= trunc_reg + 1'b1;
        end
      end

      assign stat_frames[gi*CNT_WIDTH +: CNT_WIDTH] = frames_reg;
      assign stat_trunc[gi*CNT_WIDTH +: CNT_WIDTH]  = trunc_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_eth_tx_frame_arb.sv
// Testbench for eth_tx_frame_arb (3 ports, MAX_FRAME_LEN = 64).
// Source beats and expected output beats are queued together. A single driver
// process presents the per-port beats. A monitor pops and compares every
// accepted output beat, together with the granted port.
`timescale 1ns/1ps

module tb_eth_tx_frame_arb;
  localparam int NP   = 3;
  localparam int MAXL = 64;
  localparam int CW   = 16;

  typedef struct packed {
    logic [2:0] port;
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NP*8-1:0] s_data;
  logic [NP-1:0]   s_valid;
  logic [NP-1:0]   s_ready;
  logic [NP-1:0]   s_last;
  logic [NP-1:0]   s_user;
  logic [7:0]      m_data;
  logic            m_valid;
  logic            m_ready;
  logic            m_last;
  logic            m_user;
  logic [2:0]      grant_port;
  logic            busy;
  logic            err;
`ifdef TX_ARB_STATS_EN
  logic [NP*CW-1:0] stat_frames;
  logic [NP*CW-1:0] stat_trunc;
`endif

  beat_t srcq[$];
  beat_t expq[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    err_pulses = 0;
  int    beats_out = 0;
  int    frames_out = 0;
  int    rise_cyc[NP];
  int    sof_cyc = 0;
  bit    sof = 1'b1;
  int    rdy_mode = 0;
  bit    gap_en = 1'b0;

  always #5 clk = ~clk;

  eth_tx_frame_arb #(
    .NUM_PORTS    (NP),
    .DATA_WIDTH   (8),
    .MAX_FRAME_LEN(MAXL),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axis_tdata   (s_data),
    .s_axis_tvalid  (s_valid),
    .s_axis_tready  (s_ready),
    .s_axis_tlast   (s_last),
    .s_axis_tuser   (s_user),
    .m_axis_tdata   (m_data),
    .m_axis_tvalid  (m_valid),
    .m_axis_tready  (m_ready),
    .m_axis_tlast   (m_last),
    .m_axis_tuser   (m_user),
    .grant_port     (grant_port),
    .busy           (busy),
    .error_truncated(err)
`ifdef TX_ARB_STATS_EN
    ,
    .stat_frames    (stat_frames),
    .stat_trunc     (stat_trunc)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // keep < len models truncation: only keep beats come out, the last one marked bad.
  task automatic push_frame(input int port, input int len, input int base, input bit user,
                            input int keep);
    beat_t b;
    beat_t e;
    for (int i = 0; i < len; i++) begin
      b.port = 3'(port);
      b.data = 8'(base + i);
      b.last = (i == len - 1);
      b.user = user && (i == len - 1);
      srcq.push_back(b);
      if (i < keep) begin
        e = b;
        if (keep < len && i == keep - 1) begin
          e.last = 1'b1;
          e.user = 1'b1;
        end
        expq.push_back(e);
      end
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while ((expq.size() != 0 || srcq.size() != 0 || busy || m_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(expq.size() + srcq.size()) + {30'b0, busy, m_valid}, 32'd0);
  endtask

  // Source and sink-ready driver: handshakes are sampled on the falling edge,
  // inputs change 1 ns after the rising edge.
  initial begin
    logic [NP-1:0] hs;
    int idx;
    s_valid = '0;
    s_data  = '0;
    s_last  = '0;
    s_user  = '0;
    m_ready = 1'b0;
    forever begin
      @(negedge clk);
      hs = s_valid & s_ready;
      @(posedge clk);
      cyc++;
      #1;
      for (int p = 0; p < NP; p++) begin
        if (hs[p]) begin
          idx = -1;
          for (int i = 0; i < srcq.size(); i++)
            if (srcq[i].port == 3'(p)) begin idx = i; break; end
          if (idx >= 0) srcq.delete(idx);
        end
        idx = -1;
        for (int i = 0; i < srcq.size(); i++)
          if (srcq[i].port == 3'(p)) begin idx = i; break; end
        if (idx < 0) begin
          s_valid[p] = 1'b0;
        end else if (!s_valid[p] || hs[p]) begin
          if (gap_en && $urandom_range(0, 3) == 0) begin
            s_valid[p] = 1'b0;
          end else begin
            if (!s_valid[p]) rise_cyc[p] = cyc;
            s_valid[p]       = 1'b1;
            s_data[p*8 +: 8] = srcq[idx].data;
            s_last[p]        = srcq[idx].last;
            s_user[p]        = srcq[idx].user;
          end
        end
      end
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 3 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor / scoreboard.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (m_valid && m_ready) begin
          if (expq.size() == 0) begin
            check("spurious_beat", 32'(expq.size()), 32'd1);
          end else begin
            e = expq.pop_front();
            check("beat", {19'b0, grant_port, m_data, m_last, m_user}, 32'(e));
            if (sof) sof_cyc = cyc;
            sof = m_last;
            beats_out++;
            if (m_last) begin
              frames_out++;
              $display("frame %0d port %0d ends data=%h user=%0d cyc=%0d",
                       frames_out, grant_port, m_data, m_user, cyc);
            end
          end
        end
        if (m_valid && !m_ready) check("hold_ready", 32'(s_ready), 32'd0);
        if (busy) check("other_ready", 32'(s_ready & ~(NP'(1) << grant_port)), 32'd0);
        if (err) err_pulses++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int target;
    int n;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset_state", {13'b0, m_valid, m_data, m_last, m_user, s_ready, grant_port, busy, err},
          32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single 60-beat frame on port 1, full throughput.
    push_frame(1, 60, 0, 1'b0, 60);
    wait_done("single_done", 400);
    check("single_latency", 32'(sof_cyc - rise_cyc[1]), 32'd2);
    check("single_grant", 32'(grant_port), 32'd1);

    // Ports 0 and 2 together: rr_ptr=2 after port 1, so port 2 goes first.
    push_frame(2, 4, 8'hA0, 1'b0, 4);
    push_frame(0, 4, 8'hB0, 1'b0, 4);
    wait_done("rr_done", 200);

    // Single-beat frame with a bad-frame flag.
    push_frame(2, 1, 8'h5A, 1'b1, 1);
    wait_done("onebeat_done", 50);

    // Asynchronous reset in the middle of a port-0 frame.
    push_frame(0, 20, 8'h60, 1'b0, 20);
    target = beats_out + 5;
    n = 0;
    while (beats_out < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reset_reach_beat5", 32'(beats_out >= target), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("reset_midframe", {13'b0, m_valid, m_data, m_last, m_user, s_ready, grant_port, busy, err},
          32'd0);
    srcq.delete();
    expq.delete();
    sof = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_frame(2, 3, 8'h70, 1'b0, 3);
    wait_done("post_reset_done", 100);

    // Contention from rr_ptr=0: order 0,1,2, then port 0's second frame.
    push_frame(0, 10, 8'h10, 1'b0, 10);
    push_frame(1, 10, 8'h20, 1'b0, 10);
    push_frame(2, 10, 8'h30, 1'b0, 10);
    push_frame(0, 10, 8'h40, 1'b0, 10);
    wait_done("contention_done", 300);

    // Backpressure 1-on/2-off with source gaps; tlast exactly on beat MAX.
    rdy_mode = 1;
    gap_en   = 1'b1;
    push_frame(1, MAXL, 8'h80, 1'b0, MAXL);
    wait_done("backpressure_done", 1000);
    check("no_trunc_at_max", 32'(err_pulses), 32'd0);
    rdy_mode = 0;
    gap_en   = 1'b0;

    // Truncation: port 0 sends MAXL+4 beats, port 1 is served afterwards.
    push_frame(0, MAXL + 4, 8'hC0, 1'b0, MAXL);
    push_frame(1, 8, 8'h05, 1'b0, 8);
    wait_done("trunc_done", 400);
    check("trunc_pulses", 32'(err_pulses), 32'd1);

`ifdef TX_ARB_STATS_EN
    @(negedge clk);
    check("stat_frames0", 32'(stat_frames[0*CW +: CW]), 32'd3);
    check("stat_frames1", 32'(stat_frames[1*CW +: CW]), 32'd3);
    check("stat_frames2", 32'(stat_frames[2*CW +: CW]), 32'd2);
    check("stat_trunc0",  32'(stat_trunc[0*CW +: CW]),  32'd1);
    check("stat_trunc1",  32'(stat_trunc[1*CW +: CW]),  32'd0);
    check("stat_trunc2",  32'(stat_trunc[2*CW +: CW]),  32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
